hit_edge_detector: RTL and testbench
====================================

# hit_edge_detector

Per-frame collision collector that sits directly upstream of the smiley movement block and drives its `collision` and `HitEdgeCode` inputs. Each clock it compares the smiley and obstacle drawing requests for the current VGA pixel, and classifies each overlapping pixel by which edge of the smiley box it lies on. It ORs those edge bits over one frame, then reports the result as a single-cycle pulse after `startOfFrame`. The mover therefore sees at most one collision event per frame, with the edge code already settled.

## Interface
Parameters:
- `OBJECT_WIDTH`, default 32: smiley box width in pixels.
- `OBJECT_HEIGHT`, default 32: smiley box height in pixels.
- `EDGE_MARGIN`, default 4: edge band thickness in pixels.
- `MIN_HIT_PIXELS`, default 8: overlap threshold. Only used with `HIT_PIXEL_THRESHOLD_EN`.

Ports:
- `clk`  in  1  pixel clock.
- `resetN`  in  1  reset, asynchronous, active-low. Clock is `clk`.
- `startOfFrame`  in  1  one-cycle pulse at each frame start.
- `pixelX`  in  11  current pixel column, unsigned.
- `pixelY`  in  11  current pixel row, unsigned.
- `topLeftX`  in  11 signed  smiley top-left column.
- `topLeftY`  in  11 signed  smiley top-left row.
- `smileyDR`  in  1  smiley drawing request for the current pixel.
- `obstacleDR`  in  1  obstacle/brick drawing request for the current pixel.
- `collision`  out  1  one-cycle pulse; the previous frame had a qualifying overlap.
- `HitEdgeCode`  out  4  edge bits {Left(3), Top(2), Right(1), Bottom(0)}.

## Operation
- **Stage 1 (registered):**
  - `overlap = smileyDR & obstacleDR`.
  - `offX = pixelX - topLeftX` and `offY = pixelY - topLeftY`, both 12-bit signed.
  - Edge bits, all comparisons signed:
    - L: `offX < EDGE_MARGIN`.
    - T: `offY < EDGE_MARGIN`.
    - R: `offX >= OBJECT_WIDTH-EDGE_MARGIN`.
    - B: `offY >= OBJECT_HEIGHT-EDGE_MARGIN`.
  - Corner pixels set two bits. Interior pixels set none but still count as overlap.
  - Stage 1 registers `overlap` and the edge bits, gated by `overlap`.
- **Stage 2 accumulators:**
  - `accEdge |= edgeBits_q`.
  - `accHit` is set by `overlap_q`.
  - `hitCnt` is a 16-bit counter, saturating at 0xFFFF.
- **FSM states:** IDLE, SCAN, REPORT.
  - IDLE: entered at reset. Discards the partial first frame. On `startOfFrame`, clear the accumulators and go to SCAN. No report is made.
  - SCAN: accumulate. On `startOfFrame`, go to REPORT and latch the accumulators into the output registers.
  - REPORT: lasts exactly one cycle, then returns to SCAN unconditionally.
- **Outputs at REPORT:**
  - `collision = accHit` (qualified by threshold when configured).
  - `HitEdgeCode = accEdge` if `collision` is 1, else 0.
  - `HitEdgeCode` holds until the next REPORT.
- **Frame-boundary rules:**
  - The accumulators restart on the same clock as `startOfFrame`.
  - If `overlap_q` is valid in that cycle, it is loaded into the new frame's accumulators, not dropped.
  - A `startOfFrame` during REPORT counts as an empty frame boundary: accumulators restart, no second pulse, next state SCAN.
- **Reset:** asserting `resetN` mid-frame clears everything immediately and returns to IDLE.

## Timing
- Reset values:
  - `collision` = 0, `HitEdgeCode` = 0.
  - State = IDLE.
  - Accumulators and `hitCnt` = 0.
  - Stage-1 registers = 0.
- Pixel-to-accumulator latency: 2 clocks. The last 2 pixels before `startOfFrame` are in blanking, so no loss.
- `collision` rises 1 clock after the `startOfFrame` cycle. It is high for exactly 1 clock.
- `HitEdgeCode` is valid in the same cycle as `collision`.
- At most one `collision` pulse per frame.

## Configuration
- `HIT_PIXEL_THRESHOLD_EN` defined:
  - `collision` requires `hitCnt >= MIN_HIT_PIXELS` at REPORT.
  - Below threshold: `collision` = 0 and `HitEdgeCode` = 0.
- `HIT_PIXEL_THRESHOLD_EN` undefined:
  - Any single overlapping pixel qualifies.
  - `hitCnt` and the compare are not built.

## Structure
- Package `hit_pkg` holds:
  - `EDGE_LEFT=3`, `EDGE_TOP=2`, `EDGE_RIGHT=1`, `EDGE_BOTTOM=0`.
  - typedef `hit_state_t` enum {IDLE, SCAN, REPORT}.
  - typedef `edge_code_t` logic [3:0].
- Sub-module `hit_edge_classifier`: combinational offset calculation and 4-bit edge classification. It is instantiated once, feeding stage 1.

## Test plan
All scenarios use the default parameters, with `topLeftX`=100 and `topLeftY`=100 unless stated.
- **Left edge:** overlap at pixel (100,115) in a SCAN frame -> one cycle after the next `startOfFrame`, `collision`=1 for 1 clock and `HitEdgeCode`=4'b1000.
- **Bottom-right corner:** overlap at (131,131) -> `HitEdgeCode`=4'b0011.
- **Interior only:** overlap at (116,116) -> `collision`=1 and `HitEdgeCode`=4'b0000.
- **No overlap:**
  - `smileyDR` active all frame, `obstacleDR`=0 -> `collision` stays 0 and `HitEdgeCode`=0.
  - A following frame with no overlap clears a previously reported code to 0.
- **Reset and IDLE discard:**
  - Overlap before the first `startOfFrame` after reset -> no pulse at the first `startOfFrame`.
  - `resetN` pulsed low mid-SCAN with overlap accumulated -> outputs 0, no pulse at the next `startOfFrame`.
- **Threshold (with `HIT_PIXEL_THRESHOLD_EN`):**
  - 7 overlapping pixels -> `collision`=0.
  - 8 overlapping pixels -> `collision`=1.
  - Back-to-back `startOfFrame` 1 clock apart -> exactly one pulse.

Source files
------------

// File: rtl/hit_pkg.sv
// Shared definitions for the hit edge detector: edge bit positions,
// FSM state encoding and the edge-code type.
package hit_pkg;

  localparam int EDGE_LEFT   = 3;
  localparam int EDGE_TOP    = 2;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_BOTTOM = 0;

  typedef logic [3:0] edge_code_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } hit_state_t;

endpackage

// File: rtl/hit_edge_classifier.sv
// Combinational edge classifier: computes the pixel offset inside the smiley
// box and flags which edge band(s) the pixel lies in. Offsets are signed so
// pixels left of / above the box count as left / top edge hits.
module hit_edge_classifier
  import hit_pkg::*;
#(
  parameter int OBJECT_WIDTH  = 32,
  parameter int OBJECT_HEIGHT = 32,
  parameter int EDGE_MARGIN   = 4
) (
  input  logic        [10:0] pixel_x_i,
  input  logic        [10:0] pixel_y_i,
  input  logic signed [10:0] top_left_x_i,
  input  logic signed [10:0] top_left_y_i,
  output edge_code_t         edge_bits_o
);

  localparam logic signed [11:0] MARGIN_S  = 12'(EDGE_MARGIN);
  localparam logic signed [11:0] RIGHT_LIM = 12'(OBJECT_WIDTH - EDGE_MARGIN);
  localparam logic signed [11:0] BOT_LIM   = 12'(OBJECT_HEIGHT - EDGE_MARGIN);

  logic signed [11:0] off_x_s;
  logic signed [11:0] off_y_s;

  // Pixel coordinates are zero-extended, top-left coordinates sign-extended.
  assign off_x_s = $signed({1'b0, pixel_x_i}) - $signed({top_left_x_i[10], top_left_x_i});
  assign off_y_s = $signed({1'b0, pixel_y_i}) - $signed({top_left_y_i[10], top_left_y_i});

  // Classify the offset into the four edge bands; corners set two bits.
  always_comb begin
    edge_bits_o              = 4'b0000;
    edge_bits_o[EDGE_LEFT]   = (off_x_s <  MARGIN_S);
    edge_bits_o[EDGE_TOP]    = (off_y_s <  MARGIN_S);
    edge_bits_o[EDGE_RIGHT]  = (off_x_s >= RIGHT_LIM);
    edge_bits_o[EDGE_BOTTOM] = (off_y_s >= BOT_LIM);
  end

endmodule

// File: rtl/hit_edge_detector.sv
// Per-frame collision collector feeding the smiley mover. Overlapping
// smiley/obstacle pixels are classified by edge, OR-ed over a frame and
// reported as a one-cycle collision pulse right after startOfFrame.
// Optional build macro: HIT_PIXEL_THRESHOLD_EN (require MIN_HIT_PIXELS
// overlapping pixels in a frame before a collision is reported).
module hit_edge_detector
  import hit_pkg::*;
#(
  parameter int OBJECT_WIDTH   = 32,
  parameter int OBJECT_HEIGHT  = 32,
  parameter int EDGE_MARGIN    = 4,
  parameter int MIN_HIT_PIXELS = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic        [10:0] pixelX,
  input  logic        [10:0] pixelY,
  input  logic signed [10:0] topLeftX,
  input  logic signed [10:0] topLeftY,
  input  logic               smileyDR,
  input  logic               obstacleDR,
  output logic               collision,
  output edge_code_t         HitEdgeCode
);

  // Stage 1
  logic       overlap_s;
  edge_code_t edge_s;
  logic       overlap_q;
  edge_code_t edge_q;

  // Stage 2 accumulators and FSM
  hit_state_t state_q,    state_d;
  edge_code_t acc_edge_q, acc_edge_d;
  logic       acc_hit_q,  acc_hit_d;
  logic       collision_q, collision_d;
  edge_code_t code_q,     code_d;
  logic       qualify_s;

  assign overlap_s = smileyDR & obstacleDR;

  hit_edge_classifier #(
    .OBJECT_WIDTH (OBJECT_WIDTH),
    .OBJECT_HEIGHT(OBJECT_HEIGHT),
    .EDGE_MARGIN  (EDGE_MARGIN)
  ) u_classifier (
    .pixel_x_i   (pixelX),
    .pixel_y_i   (pixelY),
    .top_left_x_i(topLeftX),
    .top_left_y_i(topLeftY),
    .edge_bits_o (edge_s)
  );

  // Stage 1 register: overlap flag and edge bits, edge bits only kept on overlap.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      overlap_q <= 1'b0;
      edge_q    <= 4'b0000;
    end else begin
      overlap_q <= overlap_s;
      edge_q    <= overlap_s ? edge_s : 4'b0000;
    end
  end

`ifdef HIT_PIXEL_THRESHOLD_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] hit_cnt_inc_s;

  assign hit_cnt_inc_s = (hit_cnt_q == 16'hFFFF) ? hit_cnt_q : (hit_cnt_q + 16'd1);

  // Overlap pixel counter: restarts on frame start, saturates, idles at zero.
  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (startOfFrame) begin
      hit_cnt_d = {15'd0, overlap_q};
    end else if ((state_q == SCAN) || (state_q == REPORT)) begin
      hit_cnt_d = overlap_q ? hit_cnt_inc_s : hit_cnt_q;
    end else begin
      hit_cnt_d = 16'd0;
    end
  end

  // Overlap pixel counter register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_cnt_q <= 16'd0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign qualify_s = acc_hit_q & (hit_cnt_q >= 16'(MIN_HIT_PIXELS));
`else
  // Any overlapping pixel qualifies; the threshold parameter has no effect.
  assign qualify_s = acc_hit_q & (MIN_HIT_PIXELS >= 0);
`endif

  // Accumulators: restart on frame start (absorbing the in-flight stage-1
  // pixel), accumulate while scanning, held clear while idle.
  always_comb begin
    acc_edge_d = acc_edge_q;
    acc_hit_d  = acc_hit_q;
    if (startOfFrame) begin
      acc_edge_d = edge_q;
      acc_hit_d  = overlap_q;
    end else if ((state_q == SCAN) || (state_q == REPORT)) begin
      acc_edge_d = acc_edge_q | edge_q;
      acc_hit_d  = acc_hit_q | overlap_q;
    end else begin
      acc_edge_d = 4'b0000;
      acc_hit_d  = 1'b0;
    end
  end

  // FSM next state and output latch; a report is made only when a frame
  // boundary is seen while scanning.
  always_comb begin
    state_d     = state_q;
    collision_d = 1'b0;
    code_d      = code_q;
    case (state_q)
      IDLE: begin
        if (startOfFrame) begin
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (startOfFrame) begin
          state_d     = REPORT;
          collision_d = qualify_s;
          code_d      = qualify_s ? acc_edge_q : 4'b0000;
        end else begin
          state_d = SCAN;
        end
      end
      REPORT: begin
        state_d = SCAN;
      end
      default: begin
        state_d = IDLE;
        code_d  = 4'b0000;
      end
    endcase
  end

  // State, accumulator and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      acc_edge_q  <= 4'b0000;
      acc_hit_q   <= 1'b0;
      collision_q <= 1'b0;
      code_q      <= 4'b0000;
    end else begin
      state_q     <= state_d;
      acc_edge_q  <= acc_edge_d;
      acc_hit_q   <= acc_hit_d;
      collision_q <= collision_d;
      code_q      <= code_d;
    end
  end

  assign collision   = collision_q;
  assign HitEdgeCode = code_q;

endmodule

// File: tb/tb_hit_edge_detector.sv
// Self-checking bench for hit_edge_detector. Expected frame reports are
// pushed to a scoreboard queue when each frame is closed and popped when the
// collision pulse is due. Threshold scenarios need HIT_PIXEL_THRESHOLD_EN.
module tb_hit_edge_detector;

  logic               clk = 1'b0;
  logic               resetN;
  logic               startOfFrame;
  logic        [10:0] pixelX;
  logic        [10:0] pixelY;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               smileyDR;
  logic               obstacleDR;
  logic               collision;
  logic        [3:0]  HitEdgeCode;

  typedef struct packed {
    logic       col;
    logic [3:0] code;
  } exp_t;

  exp_t sb[$];
  exp_t exp_v;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hit_edge_detector dut (
    .clk         (clk),
    .resetN      (resetN),
    .startOfFrame(startOfFrame),
    .pixelX      (pixelX),
    .pixelY      (pixelY),
    .topLeftX    (topLeftX),
    .topLeftY    (topLeftY),
    .smileyDR    (smileyDR),
    .obstacleDR  (obstacleDR),
    .collision   (collision),
    .HitEdgeCode (HitEdgeCode)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input int x, input int y, input logic s, input logic o);
    pixelX     = 11'(x);
    pixelY     = 11'(y);
    smileyDR   = s;
    obstacleDR = o;
    cyc();
    smileyDR   = 1'b0;
    obstacleDR = 1'b0;
  endtask

  // Two blanking cycles, record the expected report, then a one-cycle SOF.
  // On return the report cycle is visible on the outputs.
  task automatic end_frame(input logic c, input logic [3:0] code);
    cyc();
    cyc();
    sb.push_back({c, code});
    startOfFrame = 1'b1;
    cyc();
    startOfFrame = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    cyc();
    checks++;
    if ({collision, HitEdgeCode} !== 5'b0_0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000", {collision, HitEdgeCode});
    end
    resetN = 1'b1;
    cyc();
    pixel(100, 115, 1'b1, 1'b1);
    end_frame(1'b0, 4'b0000);
    exp_v = sb.pop_front();
    checks++;
    if ({collision, HitEdgeCode} !== {exp_v.col, exp_v.code}) begin
      errors++;
      $display("FAIL idle_discard: got %b expected %b", {collision, HitEdgeCode}, exp_v);
    end
  endtask

  task automatic test_single(input string name, input int x, input int y,
                             input logic c, input logic [3:0] code);
    pixel(x, y, 1'b1, 1'b1);
    end_frame(c, code);
    exp_v = sb.pop_front();
    checks++;
    if ({collision, HitEdgeCode} !== {exp_v.col, exp_v.code}) begin
      errors++;
      $display("FAIL %s_pulse: got %b expected %b", name, {collision, HitEdgeCode}, exp_v);
    end
    cyc();
    checks++;
    if ({collision, HitEdgeCode} !== {1'b0, exp_v.code}) begin
      errors++;
      $display("FAIL %s_hold: got %b expected %b", name, {collision, HitEdgeCode}, {1'b0, exp_v.code});
    end
  endtask

  task automatic test_no_overlap();
    smileyDR = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pixelX = 11'(100 + i);
      pixelY = 11'(100 + i);
      cyc();
    end
    smileyDR = 1'b0;
    end_frame(1'b0, 4'b0000);
    exp_v = sb.pop_front();
    checks++;
    if ({collision, HitEdgeCode} !== {exp_v.col, exp_v.code}) begin
      errors++;
      $display("FAIL no_overlap: got %b expected %b", {collision, HitEdgeCode}, exp_v);
    end
  endtask

  task automatic test_or_boundaries();
    pixel(97, 97, 1'b1, 1'b1);    // offsets -3,-3: left+top
    pixel(128, 115, 1'b1, 1'b1);  // offX 28: right band starts
    pixel(127, 100, 1'b1, 1'b1);  // offX 27 not right, offY 0 top
    pixel(131, 110, 1'b1, 1'b0);  // no overlap, must not contribute
    end_frame(1'b1, 4'b1110);
    exp_v = sb.pop_front();
    checks++;
    if ({collision, HitEdgeCode} !== {exp_v.col, exp_v.code}) begin
      errors++;
      $display("FAIL or_edges: got %b expected %b", {collision, HitEdgeCode}, exp_v);
    end
  endtask

  task automatic test_boundary_carry();
    pixel(116, 100, 1'b1, 1'b1);  // top edge, still in stage 1 at SOF
    sb.push_back({1'b0, 4'b0000});
    startOfFrame = 1'b1;
    cyc();
    startOfFrame = 1'b0;
    exp_v = sb.pop_front();
    checks++;
    if ({collision, HitEdgeCode} !== {exp_v.col, exp_v.code}) begin
      errors++;
      $display("FAIL carry_old_frame: got %b expected %b", {collision, HitEdgeCode}, exp_v);
    end
    end_frame(1'b1, 4'b0100);
    exp_v = sb.pop_front();
    checks++;
    if ({collision, HitEdgeCode} !== {exp_v.col, exp_v.code}) begin
      errors++;
      $display("FAIL carry_new_frame: got %b expected %b", {collision, HitEdgeCode}, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    pixel(100, 100, 1'b1, 1'b1);
    cyc();
    cyc();
    sb.push_back({1'b1, 4'b1100});
    startOfFrame = 1'b1;
    cyc();
    exp_v = sb.pop_front();
    checks++;
    if ({collision, HitEdgeCode} !== {exp_v.col, exp_v.code}) begin
      errors++;
      $display("FAIL b2b_first: got %b expected %b", {collision, HitEdgeCode}, exp_v);
    end
    cyc();  // SOF seen during REPORT
    startOfFrame = 1'b0;
    checks++;
    if ({collision, HitEdgeCode} !== 5'b0_1100) begin
      errors++;
      $display("FAIL b2b_second: got %b expected 01100", {collision, HitEdgeCode});
    end
    end_frame(1'b0, 4'b0000);
    exp_v = sb.pop_front();
    checks++;
    if ({collision, HitEdgeCode} !== {exp_v.col, exp_v.code}) begin
      errors++;
      $display("FAIL b2b_after: got %b expected %b", {collision, HitEdgeCode}, exp_v);
    end
  endtask

  task automatic test_reset_mid_scan();
    pixel(100, 115, 1'b1, 1'b1);
    end_frame(1'b1, 4'b1000);
    exp_v = sb.pop_front();
    checks++;
    if ({collision, HitEdgeCode} !== {exp_v.col, exp_v.code}) begin
      errors++;
      $display("FAIL rst_prior: got %b expected %b", {collision, HitEdgeCode}, exp_v);
    end
    pixel(116, 116, 1'b1, 1'b1);
    cyc();
    #2 resetN = 1'b0;
    #1;
    checks++;
    if ({collision, HitEdgeCode} !== 5'b0_0000) begin
      errors++;
      $display("FAIL rst_async: got %b expected 00000", {collision, HitEdgeCode});
    end
    cyc();
    resetN = 1'b1;
    end_frame(1'b0, 4'b0000);
    exp_v = sb.pop_front();
    checks++;
    if ({collision, HitEdgeCode} !== {exp_v.col, exp_v.code}) begin
      errors++;
      $display("FAIL rst_no_pulse: got %b expected %b", {collision, HitEdgeCode}, exp_v);
    end
  endtask

  task automatic test_pixel_count(input int n, input logic c, input logic [3:0] code);
    for (int i = 0; i < n; i++) begin
      pixel(100, 100 + i, 1'b1, 1'b1);
    end
    end_frame(c, code);
    exp_v = sb.pop_front();
    checks++;
    if ({collision, HitEdgeCode} !== {exp_v.col, exp_v.code}) begin
      errors++;
      $display("FAIL count_%0d: got %b expected %b", n, {collision, HitEdgeCode}, exp_v);
    end
  endtask

  initial begin
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    pixelX       = 11'd0;
    pixelY       = 11'd0;
    topLeftX     = 11'sd100;
    topLeftY     = 11'sd100;
    smileyDR     = 1'b0;
    obstacleDR   = 1'b0;

    test_reset();
    test_single("left", 100, 115, 1'b1, 4'b1000);
    test_no_overlap();
    test_single("corner_br", 131, 131, 1'b1, 4'b0011);
    test_single("interior", 116, 116, 1'b1, 4'b0000);
    test_or_boundaries();
    test_boundary_carry();
    test_back_to_back();
    test_reset_mid_scan();
`ifdef HIT_PIXEL_THRESHOLD_EN
    test_pixel_count(7, 1'b0, 4'b0000);
    test_pixel_count(8, 1'b1, 4'b1100);
`else
    test_pixel_count(1, 1'b1, 4'b1100);
    test_pixel_count(8, 1'b1, 4'b1100);
`endif
    // Negative top-left: pixel 0 sits at offset 2, inside the left band.
    topLeftX = -11'sd2;
    topLeftY = 11'sd0;
    test_single("neg_origin", 0, 10, 1'b1, 4'b1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
